// File: rtl/j1_io_uart_pkg.sv
// Shared definitions for the j1 I/O-bus UART: address decode bits,
// status word layout and the RX/TX state encodings.
package j1_io_uart_pkg;

    localparam int IO_UART_DATA_BIT = 12;
    localparam int IO_UART_STAT_BIT = 13;

    localparam int ST_TX_BUSY   = 0;
    localparam int ST_RX_AVAIL  = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_FRAME_ERR = 3;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic {
        TX_IDLE  = 1'b0,
        TX_SHIFT = 1'b1
    } tx_state_t;

    function automatic logic [15:0] status_word(input logic frame_err,
                                                input logic overrun,
                                                input logic rx_avail,
                                                input logic tx_busy);
        logic [15:0] w;
        w               = 16'h0000;
        w[ST_FRAME_ERR] = frame_err;
        w[ST_OVERRUN]   = overrun;
        w[ST_RX_AVAIL]  = rx_avail;
        w[ST_TX_BUSY]   = tx_busy;
        return w;
    endfunction

endpackage

// File: rtl/j1_io_uart_fifo.sv
// Small synchronous FIFO for received bytes; pointers carry one extra
// wrap bit so full and empty are distinguishable without a counter.
module io_uart_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head  = mem[rptr[AW-1:0]];

    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + PTR_ONE;
            if (do_pop)
                rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/j1_io_uart.sv
// UART target on the j1 I/O bus: 8N1 transmitter, oversampled receiver
// feeding a small FIFO, and a DATA/STATUS register pair.
module j1_io_uart
    import j1_io_uart_pkg::*;
#(
    parameter int CLKDIV     = 104,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_dout,
    output logic [15:0] io_din,
    input  logic        uart_rx,
    output logic        uart_tx
);

    localparam int CW = $clog2(CLKDIV);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKDIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKDIV / 2 - 1);

    logic data_sel;
    logic stat_sel;
    logic rd_pop;
    logic stat_clr;

    logic [7:0] fifo_head;
    logic       fifo_full;
    logic       fifo_empty;

    logic overrun;
    logic frame_err;
    logic overrun_set;
    logic frame_set;

    tx_state_t  tx_state;
    logic       tx_busy;
    logic [CW-1:0] tx_cnt;
    logic [3:0] tx_bits;
    logic [8:0] tx_shift;

    logic [1:0] rx_sync;
    logic       rx_s;
    rx_state_t  rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0] rx_bits;
    logic [7:0] rx_shift;
    logic       rx_wait;
    logic       rx_sample;
    logic       rx_push;

    logic unused_bus_bits;
    assign unused_bus_bits = ^{io_addr[15:14], io_addr[11:0], io_dout[15:8]};

    assign data_sel = io_addr[IO_UART_DATA_BIT];
    assign stat_sel = !io_addr[IO_UART_DATA_BIT] && io_addr[IO_UART_STAT_BIT];
    assign rd_pop   = io_rd && data_sel;
    assign stat_clr = io_rd && stat_sel;

    always_comb begin
        io_din = 16'h0000;
        if (data_sel)
            io_din = {8'h00, (fifo_empty ? 8'h00 : fifo_head)};
        else if (stat_sel)
            io_din = status_word(frame_err, overrun, !fifo_empty, tx_busy);
    end

    io_uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk    (clk),
        .resetq (resetq),
        .push   (rx_push),
        .pop    (rd_pop),
        .din    (rx_shift),
        .head   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Transmitter: start bit goes out on the cycle after the write, stop bit is bit 8 of the shifter.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            tx_state <= TX_IDLE;
            tx_busy  <= 1'b0;
            uart_tx  <= 1'b1;
            tx_cnt   <= '0;
            tx_bits  <= 4'd0;
            tx_shift <= '1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (io_wr && data_sel) begin
                        tx_state <= TX_SHIFT;
                        tx_busy  <= 1'b1;
                        uart_tx  <= 1'b0;
                        tx_shift <= {1'b1, io_dout[7:0]};
                        tx_cnt   <= '0;
                        tx_bits  <= 4'd0;
                    end
                end
                TX_SHIFT: begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bits == 4'd9) begin
                            tx_state <= TX_IDLE;
                            tx_busy  <= 1'b0;
                            uart_tx  <= 1'b1;
                        end else begin
                            tx_bits  <= tx_bits + 4'd1;
                            uart_tx  <= tx_shift[0];
                            tx_shift <= {1'b1, tx_shift[8:1]};
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq)
            rx_sync <= 2'b11;
        else
            rx_sync <= {rx_sync[0], uart_rx};
    end

    assign rx_s      = rx_sync[1];
    assign rx_sample = (rx_cnt == CNT_LAST);
    assign rx_push   = (rx_state == RX_STOP) && !rx_wait && rx_sample && rx_s;
    assign frame_set = (rx_state == RX_STOP) && !rx_wait && rx_sample && !rx_s;

    // Receiver: re-check the start bit at mid-bit, then sample every bit period from there.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bits  <= 3'd0;
            rx_shift <= 8'h00;
            rx_wait  <= 1'b0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt  <= '0;
                    rx_wait <= 1'b0;
                    if (!rx_s)
                        rx_state <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt == CNT_HALF) begin
                        rx_cnt   <= '0;
                        rx_bits  <= 3'd0;
                        rx_state <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (rx_sample) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s, rx_shift[7:1]};
                        rx_bits  <= rx_bits + 3'd1;
                        if (rx_bits == 3'd7)
                            rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (rx_wait) begin
                        if (rx_s) begin
                            rx_wait  <= 1'b0;
                            rx_state <= RX_IDLE;
                        end
                    end else if (rx_sample) begin
                        rx_cnt <= '0;
                        if (rx_s)
                            rx_state <= RX_IDLE;
                        else
                            rx_wait <= 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    assign overrun_set = rx_push && fifo_full && !rd_pop;

    // Sticky error flags: a STATUS read clears them, but a new event in that cycle wins.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (overrun_set)
                overrun <= 1'b1;
            else if (stat_clr)
                overrun <= 1'b0;
            if (frame_set)
                frame_err <= 1'b1;
            else if (stat_clr)
                frame_err <= 1'b0;
        end
    end

endmodule
